// File: rtl/food_map_pkg.sv
// Shared definitions for the food-map arbiter.
//  - Default geometry (ROWS_DEF x COLS_DEF map, CNT_W_DEF-bit pellet counter)
//  - FSM state encoding
//  - popcount_row: number of set bits in a row of up to MAX_COLS pellets
package food_map_pkg;

  localparam int ROWS_DEF  = 48;
  localparam int COLS_DEF  = 80;
  localparam int CNT_W_DEF = 12;
  localparam int MAX_COLS  = 127;  // keeps any row popcount inside 7 bits

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EAT_RD  = 3'd1,
    S_EAT_CAP = 3'd2,
    S_EAT_WR  = 3'd3,
    S_REFILL  = 3'd4
  } state_e;

  function automatic logic [6:0] popcount_row(input logic [MAX_COLS-1:0] row);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_COLS; i++) begin
      cnt = cnt + 7'(row[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/food_map_arbiter_popcount.sv
// row_popcount: combinational count of the pellets present in one map row.
//  row_i  in  COLS  row bitmap
//  cnt_o  out 7     number of set bits in row_i
module row_popcount
  import food_map_pkg::*;
#(
  parameter int COLS = COLS_DEF
) (
  input  logic [COLS-1:0] row_i,
  output logic [6:0]      cnt_o
);

  logic [MAX_COLS-1:0] row_pad;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    row_pad            = '0;
    row_pad[COLS-1:0]  = row_i;
    cnt_o              = popcount_row(row_pad);
  end

endmodule

// File: rtl/food_map_arbiter.sv
// food_map_arbiter: sole owner of the single-port food-map RAM.
// Shares the port between the video row fetch (highest priority, granted in
// its own cycle), the map refill sequencer and the pellet-eat read-modify-write,
// and keeps a live count of remaining pellets.
//  clk, rst                     clock, synchronous active-high reset
//  vid_req/vid_y                row fetch request; vid_row/vid_vld two cycles later
//  eat_req/eat_x/eat_y          eat request (level); eat_ack/eat_hit on completion
//  refill_start                 reload the map; init_y/init_row talk to the pattern ROM
//  busy, food_left, all_eaten   refill status and pellet bookkeeping
//  ram_addr/ram_we/ram_din/ram_dout  RAM port (1-cycle synchronous read)
module food_map_arbiter
  import food_map_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vid_req,
  input  logic [5:0]       vid_y,
  output logic [COLS-1:0]  vid_row,
  output logic             vid_vld,
  input  logic             eat_req,
  input  logic [6:0]       eat_x,
  input  logic [5:0]       eat_y,
  output logic             eat_ack,
  output logic             eat_hit,
  input  logic             refill_start,
  output logic [5:0]       init_y,
  input  logic [COLS-1:0]  init_row,
  output logic             busy,
  output logic [CNT_W-1:0] food_left,
  output logic             all_eaten,
  output logic [5:0]       ram_addr,
  output logic             ram_we,
  output logic [COLS-1:0]  ram_din,
  input  logic [COLS-1:0]  ram_dout
);

  state_e           state_q;
  logic [5:0]       r_q;
  logic [CNT_W-1:0] food_left_q;
  logic             busy_q, done_q, pend_q, wait_drop_q;
  logic             eat_ack_q, eat_hit_q;
  logic             vid_p1_q, vid_vld_q;
  logic [COLS-1:0]  vid_row_q, row_buf_q, row_clr;
  logic [6:0]       init_pop;
  logic             in_range, row_hit, eat_done, refill_go, refill_enter, last_row;

  row_popcount #(.COLS(COLS)) u_popcount (
    .row_i (init_row),
    .cnt_o (init_pop)
  );

  always_comb begin
    in_range     = (eat_x < 7'(COLS)) && ({1'b0, eat_y} < 7'(ROWS));
    row_hit      = row_buf_q[eat_x];
    row_clr      = row_buf_q;
    row_clr[eat_x] = 1'b0;
    // Out-of-range requests finish in EAT_RD without touching the RAM; the
    // write phase finishes on the first cycle video leaves the port free.
    eat_done     = (state_q == S_EAT_RD && !in_range) ||
                   (state_q == S_EAT_WR && !vid_req);
    refill_go    = refill_start || pend_q;
    refill_enter = (state_q == S_IDLE && refill_go) ||
                   (state_q == S_REFILL && refill_start) ||
                   (eat_done && refill_go);
    last_row     = (r_q == 6'(ROWS - 1));
  end

  // RAM port mux: video always wins; nothing reaches the RAM during reset.
  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (!rst) begin
      if (vid_req) begin
        ram_addr = vid_y;
      end else begin
        case (state_q)
          S_EAT_RD: if (in_range) ram_addr = eat_y;
          S_EAT_WR: if (row_hit) begin
            ram_addr = eat_y;
            ram_we   = 1'b1;
            ram_din  = row_clr;
          end
          // A restart request drops this cycle's write and rewinds to row 0.
          S_REFILL: if (!refill_start) begin
            ram_addr = r_q;
            ram_we   = 1'b1;
            ram_din  = init_row;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      food_left_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      wait_drop_q <= 1'b0;
      eat_ack_q   <= 1'b0;
      eat_hit_q   <= 1'b0;
    end else begin
      eat_ack_q <= 1'b0;
      eat_hit_q <= 1'b0;
      if (wait_drop_q && !eat_req) wait_drop_q <= 1'b0;
      if (refill_start && state_q != S_IDLE && state_q != S_REFILL) pend_q <= 1'b1;

      case (state_q)
        S_IDLE:    if (eat_req && !wait_drop_q) state_q <= S_EAT_RD;
        S_EAT_RD:  if (!in_range) state_q <= S_IDLE;
                   else if (!vid_req) state_q <= S_EAT_CAP;
        S_EAT_CAP: state_q <= S_EAT_WR;
        S_EAT_WR:  if (!vid_req) begin
          state_q <= S_IDLE;
          if (row_hit && food_left_q != '0) food_left_q <= food_left_q - CNT_W'(1);
        end
        S_REFILL:  if (!vid_req) begin
          food_left_q <= food_left_q + CNT_W'(init_pop);
          if (last_row) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            r_q <= r_q + 6'd1;
          end
        end
        default:   state_q <= S_IDLE;
      endcase

      // The requester holds eat_req through the ack cycle; ignore it until it drops.
      if (eat_done) begin
        eat_ack_q   <= 1'b1;
        eat_hit_q   <= (state_q == S_EAT_WR) && row_hit;
        wait_drop_q <= 1'b1;
      end

      // Refill entry overrides whatever the case above chose.
      if (refill_enter) begin
        state_q     <= S_REFILL;
        r_q         <= '0;
        food_left_q <= '0;
        busy_q      <= 1'b1;
        pend_q      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_p1_q  <= 1'b0;
      vid_vld_q <= 1'b0;
      vid_row_q <= '0;
    end else begin
      vid_p1_q  <= vid_req;
      vid_vld_q <= vid_p1_q;
      if (vid_p1_q) vid_row_q <= ram_dout;
    end
  end

  // NOTE: row_buf is a pure data capture that is always written before it is
  // read, so it carries no reset (like the RAM itself).
  always_ff @(posedge clk) begin
    if (state_q == S_EAT_CAP) row_buf_q <= ram_dout;
  end

  assign vid_row   = vid_row_q;
  assign vid_vld   = vid_vld_q;
  assign eat_ack   = eat_ack_q;
  assign eat_hit   = eat_hit_q;
  assign init_y    = r_q;
  assign busy      = busy_q;
  assign food_left = food_left_q;
  assign all_eaten = (food_left_q == '0) && !busy_q && done_q;

endmodule

// File: tb/tb_food_map_arbiter.sv
module tb_food_map_arbiter;

  localparam int COLS  = 80;
  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst, vid_req, eat_req, refill_start;
  logic [5:0]       vid_y, eat_y, init_y, ram_addr;
  logic [6:0]       eat_x;
  logic [COLS-1:0]  vid_row, init_row, ram_din, ram_dout;
  logic             vid_vld, eat_ack, eat_hit, busy, all_eaten, ram_we;
  logic [CNT_W-1:0] food_left;

  logic [COLS-1:0]  mem [64];
  int               wr_cnt = 0;
  logic             pat_ones;
  int               n_checks = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  food_map_arbiter dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_y(vid_y), .vid_row(vid_row), .vid_vld(vid_vld),
    .eat_req(eat_req), .eat_x(eat_x), .eat_y(eat_y), .eat_ack(eat_ack), .eat_hit(eat_hit),
    .refill_start(refill_start), .init_y(init_y), .init_row(init_row),
    .busy(busy), .food_left(food_left), .all_eaten(all_eaten),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM with 1-cycle synchronous read.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wr_cnt        <= wr_cnt + 1;
    end
    ram_dout <= mem[ram_addr];
  end

  // Init-pattern ROM: all ones, or a single pellet at row 7 column 11.
  always_comb begin
    init_row = '0;
    if (pat_ones) init_row = '1;
    else if (init_y == 6'd7) init_row[11] = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_refill(input int n_vid, output int busy_cycles);
    refill_start = 1'b1;
    tick();
    refill_start = 1'b0;
    busy_cycles  = 0;
    while (busy && busy_cycles < 200) begin
      vid_req = (busy_cycles < n_vid);
      vid_y   = 6'd0;
      busy_cycles++;
      tick();
    end
    vid_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_eat(input logic [6:0] x, input logic [5:0] y,
                        output int lat, output logic hit, output int wr);
    int w0;
    w0      = wr_cnt;
    eat_x   = x;
    eat_y   = y;
    eat_req = 1'b1;
    lat     = 0;
    hit     = 1'b0;
    while (lat < 20) begin
      tick();
      lat++;
      if (eat_ack) begin
        hit = eat_hit;
        break;
      end
    end
    eat_req = 1'b0;
    tick();
    check("eat_ack single pulse", eat_ack, 1'b0);
    wr = wr_cnt - w0;
  endtask

  typedef struct {
    logic [6:0] x;
    logic [5:0] y;
    int         exp_lat;
    logic       exp_hit;
    int         exp_left;
    int         exp_wr;
  } eat_vec_t;

  eat_vec_t vecs [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int              bc, lat, wr, w0, ack_cycle, vld_cnt;
    logic            hit, ack_hit;
    logic [15:0]     vld_mask;
    logic [COLS-1:0] exp_row;

    for (int i = 0; i < 64; i++) mem[i] = '0;
    vecs[0] = '{7'd5,   6'd3,  4, 1'b1, 3839, 1};
    vecs[1] = '{7'd5,   6'd3,  4, 1'b0, 3839, 0};
    vecs[2] = '{7'd0,   6'd0,  4, 1'b1, 3838, 1};
    vecs[3] = '{7'd79,  6'd47, 4, 1'b1, 3837, 1};
    vecs[4] = '{7'd80,  6'd0,  2, 1'b0, 3837, 0};
    vecs[5] = '{7'd90,  6'd3,  2, 1'b0, 3837, 0};
    vecs[6] = '{7'd0,   6'd48, 2, 1'b0, 3837, 0};
    vecs[7] = '{7'd79,  6'd47, 4, 1'b0, 3837, 0};
    vecs[8] = '{7'd127, 6'd63, 2, 1'b0, 3837, 0};

    rst = 1'b1; vid_req = 1'b0; vid_y = '0; eat_req = 1'b0; eat_x = '0; eat_y = '0;
    refill_start = 1'b0; pat_ones = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset busy", busy, 1'b0);
    check("reset food_left", food_left, 0);
    check("reset all_eaten before any refill", all_eaten, 1'b0);
    check("reset eat_ack", eat_ack, 1'b0);
    check("reset vid_vld", vid_vld, 1'b0);

    // Full refill with all-ones pattern.
    w0 = wr_cnt;
    do_refill(0, bc);
    check("refill busy cycles", bc, 48);
    check("refill food_left", food_left, 3840);
    check("refill all_eaten", all_eaten, 1'b0);
    check("refill write count", wr_cnt - w0, 48);

    // Table-driven eats, including column/row boundaries and out-of-range.
    for (int i = 0; i < 9; i++) begin
      do_eat(vecs[i].x, vecs[i].y, lat, hit, wr);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d eat_hit", i), hit, vecs[i].exp_hit);
      check($sformatf("vec%0d food_left", i), food_left, vecs[i].exp_left);
      check($sformatf("vec%0d writes", i), wr, vecs[i].exp_wr);
    end
    exp_row = '1;
    exp_row[5] = 1'b0;
    check("row 3 after eat", mem[3], exp_row);

    // Video every cycle for 10 cycles while an eat is pending.
    w0 = wr_cnt; vld_mask = '0; vld_cnt = 0; ack_cycle = -1; ack_hit = 1'b0;
    eat_x = 7'd10; eat_y = 6'd2;
    for (int c = 0; c < 15; c++) begin
      vid_req = (c < 10);
      vid_y   = 6'(10 + c);
      if (c == 0) eat_req = 1'b1;
      tick();
      if (vid_vld) begin
        vld_mask[c+1] = 1'b1;
        vld_cnt++;
        check($sformatf("video row cycle %0d", c + 1), vid_row, {COLS{1'b1}});
      end
      if (eat_ack) begin
        ack_cycle = c + 1;
        ack_hit   = eat_hit;
        eat_req   = 1'b0;
      end
    end
    vid_req = 1'b0;
    check("video vld count", vld_cnt, 10);
    check("video vld timing", vld_mask, 16'h0FFC);
    check("preempted eat ack cycle", ack_cycle, 13);
    check("preempted eat hit", ack_hit, 1'b1);
    check("preempted eat writes", wr_cnt - w0, 1);
    check("preempted eat food_left", food_left, 3836);
    tick();

    // refill_start while the RMW is in EAT_CAP.
    w0 = wr_cnt;
    eat_x = 7'd20; eat_y = 6'd5; eat_req = 1'b1;
    tick();
    tick();
    refill_start = 1'b1;
    tick();
    refill_start = 1'b0;
    tick();
    check("pending refill eat_ack", eat_ack, 1'b1);
    check("pending refill eat_hit", eat_hit, 1'b1);
    check("pending refill busy", busy, 1'b1);
    eat_req = 1'b0;
    bc = 0;
    while (busy && bc < 200) begin
      bc++;
      tick();
    end
    check("pending refill busy cycles", bc, 48);
    check("pending refill food_left", food_left, 3840);
    check("pending refill writes", wr_cnt - w0, 49);
    check("row 5 restored", mem[5], {COLS{1'b1}});

    // Single-pellet map, refill stalled by three video grants.
    pat_ones = 1'b0;
    do_refill(3, bc);
    check("single refill busy cycles", bc, 51);
    check("single refill food_left", food_left, 1);
    check("single refill all_eaten", all_eaten, 1'b0);
    do_eat(7'd11, 6'd7, lat, hit, wr);
    check("last pellet hit", hit, 1'b1);
    check("last pellet food_left", food_left, 0);
    check("last pellet all_eaten", all_eaten, 1'b1);
    do_eat(7'd11, 6'd7, lat, hit, wr);
    check("re-eat hit", hit, 1'b0);
    check("re-eat food_left", food_left, 0);
    check("re-eat writes", wr, 0);

    // Reset in the middle of a refill.
    refill_start = 1'b1;
    tick();
    refill_start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("no write during reset", ram_we, 1'b0);
    tick();
    rst = 1'b0;
    check("mid-refill reset busy", busy, 1'b0);
    check("mid-refill reset food_left", food_left, 0);
    check("mid-refill reset all_eaten", all_eaten, 1'b0);
    w0 = wr_cnt;
    repeat (5) tick();
    check("idle after reset writes", wr_cnt - w0, 0);
    check("idle after reset all_eaten", all_eaten, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
